shift_normalizer: RTL and testbench
===================================

// Module: shift_normalizer
// PURPOSE
//  Inverse of the barrel shifter (main). The shifter applies a given shift amount;
//  this block recovers it. It takes a word and finds its leading-zero count
//  (DIRECTION=1) or trailing-zero count (DIRECTION=0). It returns that count and the
//  word shifted so the first set bit lands at the MSB (or the LSB).
//  Iterative binary search, one stage per clock, valid/ready on both sides.
//  Sits downstream of the shifter for normalization and shift-amount recovery.
// PARAMETERS
//  DATA_SIZE  16  word width; power of two, >= 4
//  DIRECTION  1   1 = count leading zeros, shift left; 0 = count trailing zeros, shift right
//  SEL_W      $clog2(DATA_SIZE)  derived (localparam); shift-amount width, same as shifter select
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   1          data_in valid
//  in_ready   out  1          block can accept a word
//  data_in    in   DATA_SIZE  word to normalize
//  out_valid  out  1          result valid
//  out_ready  in   1          consumer accepts result
//  data_out   out  DATA_SIZE  normalized word
//  shift_amt  out  SEL_W      recovered shift count
//  zero       out  1          data_in was all zeros
// BEHAVIOUR
//  - Reset (clk edge with rst=1): state=IDLE; in_ready=1; out_valid=0; data_out=0;
//    shift_amt=0; zero=0. rst overrides every other input, including mid-SCAN and in DONE.
//  - FSM IDLE -> SCAN -> DONE -> IDLE.
//  - IDLE:
//      in_ready=1.
//      On in_valid: latch word into work reg, clear amt reg, set zero=(data_in==0),
//      stage k=0, go to SCAN.
//  - SCAN: in_ready=0. Each cycle k = 0..SEL_W-1 runs one stage:
//      half = DATA_SIZE >> (k+1).
//      DIRECTION=1: if work[DATA_SIZE-1 -: half]==0, then work <<= half and amt[SEL_W-1-k]=1.
//      DIRECTION=0: if work[half-1:0]==0, then work >>= half and amt[SEL_W-1-k]=1.
//      Vacated bits fill with 0. After stage SEL_W-1, go to DONE.
//  - DONE:
//      out_valid=1. data_out, shift_amt and zero are stable while out_valid=1.
//      On out_ready: out_valid=0 next cycle, go to IDLE.
//  - Latency: in_valid accepted at edge N; out_valid=1 after edge N+SEL_W.
//    Throughput is one word per SEL_W+2 cycles when out_ready=1.
//  - in_ready is 0 outside IDLE. in_valid asserted during SCAN/DONE is ignored, not queued.
//  - Zero input: the search shifts at every stage, so shift_amt=DATA_SIZE-1 (all ones),
//    data_out=0, zero=1.
//  - MSB set (DIRECTION=1) or LSB set (DIRECTION=0): shift_amt=0, data_out=data_in.
//  - Invariant for nonzero input: data_out == data_in << shift_amt (or >>), and
//    data_out[DATA_SIZE-1]=1 (or data_out[0]=1).
//  - out_ready held low: DONE holds indefinitely and outputs do not change.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE/SCAN/DONE, 2 bits) and the
//    direction constants DIR_LEFT=1 / DIR_RIGHT=0, used by both the shifter and this block.
//  - One sub-module: norm_stage. It is combinational, takes (word, half, dir) and returns
//    (shifted word, hit bit). It is instantiated once and time-multiplexed over k.
//  - Stage counter is SEL_W bits wide. No other state beyond the work, amt and zero regs.
// TESTING
//  1. DIR=1, 0x1901 -> out_valid at N+4; data_out=0xC808, shift_amt=3, zero=0.
//  2. DIR=1, 0x978B -> shift_amt=0, data_out=0x978B. Also 0x0001 -> shift_amt=15, data_out=0x8000.
//  3. DIR=1, 0x0000 -> zero=1, shift_amt=15, data_out=0x0000.
//  4. DIR=0, 0x1188 -> shift_amt=3, data_out=0x0231. Also 0x8000 -> shift_amt=15, data_out=0x0001.
//  5. out_ready=0 for 5 cycles in DONE -> outputs frozen and in_ready=0.
//     in_valid pulsed meanwhile with 0x00F0 is dropped, not queued. Then out_ready=1 -> IDLE.
//  6. rst=1 at SCAN stage 2 -> next cycle IDLE, all outputs at reset values.
//     A new word 0x0100 then gives shift_amt=7, data_out=0x8000.
//  Scoreboard: random 1000 words per DIRECTION checked against the reference
//  clz/ctz model and the shift invariant.

Source files
------------

// File: rtl/shift_normalizer_pkg.sv
// Shared definitions for the shifter / normalizer pair: FSM encoding and direction codes.
package shift_normalizer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } norm_state_e;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/shift_normalizer_norm_stage.sv
// One binary-search stage: tests the outer half-window and shifts it out when it is empty.
module norm_stage
  import shift_normalizer_pkg::*;
#(
  parameter int unsigned  DATA_SIZE = 16,
  localparam int unsigned SEL_W     = $clog2(DATA_SIZE)
) (
  input  logic [DATA_SIZE-1:0] i_word,
  input  logic [SEL_W-1:0]     i_half,
  input  logic                 i_dir,
  output logic [DATA_SIZE-1:0] o_word,
  output logic                 o_hit
);

  logic [DATA_SIZE-1:0] w_ones;
  logic [DATA_SIZE-1:0] w_mask;

  assign w_ones = '1;

  // Mask selects the top (left) or bottom (right) i_half bits of the word.
  always_comb begin
    w_mask = '0;
    o_hit  = 1'b0;
    o_word = i_word;
    if (i_dir == DIR_LEFT) begin
      w_mask = ~(w_ones >> i_half);
      o_hit  = (i_word & w_mask) == '0;
      o_word = o_hit ? (i_word << i_half) : i_word;
    end else begin
      w_mask = ~(w_ones << i_half);
      o_hit  = (i_word & w_mask) == '0;
      o_word = o_hit ? (i_word >> i_half) : i_word;
    end
  end

endmodule

// File: rtl/shift_normalizer.sv
// Iterative leading/trailing-zero normalizer: recovers the shift amount a barrel shifter applied.
module shift_normalizer
  import shift_normalizer_pkg::*;
#(
  parameter int unsigned  DATA_SIZE = 16,
  parameter bit           DIRECTION = DIR_LEFT,
  localparam int unsigned SEL_W     = $clog2(DATA_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] data_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] data_out,
  output logic [SEL_W-1:0]     shift_amt,
  output logic                 zero
);

  localparam logic [SEL_W-1:0] K_LAST = SEL_W'(SEL_W - 1);

  norm_state_e          r_state;
  logic [DATA_SIZE-1:0] r_work;
  logic [SEL_W-1:0]     r_amt;
  logic [SEL_W-1:0]     r_k;
  logic                 r_zero;
  logic                 r_in_ready;
  logic                 r_out_valid;

  logic [31:0]          w_k_ext;
  logic [SEL_W-1:0]     w_half;
  logic [SEL_W-1:0]     w_bitpos;
  logic [SEL_W-1:0]     w_amt_set;
  logic [DATA_SIZE-1:0] w_stage_word;
  logic                 w_hit;

  // Stage k examines a window of DATA_SIZE >> (k+1) bits and owns amt bit SEL_W-1-k.
  assign w_k_ext   = {{(32 - SEL_W){1'b0}}, r_k};
  assign w_half    = SEL_W'(DATA_SIZE >> (w_k_ext + 32'd1));
  assign w_bitpos  = K_LAST - r_k;
  assign w_amt_set = {{(SEL_W - 1){1'b0}}, w_hit} << w_bitpos;

  norm_stage #(
    .DATA_SIZE(DATA_SIZE)
  ) u_stage (
    .i_word(r_work),
    .i_half(w_half),
    .i_dir (DIRECTION),
    .o_word(w_stage_word),
    .o_hit (w_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_work      <= '0;
      r_amt       <= '0;
      r_k         <= '0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_work     <= data_in;
            r_amt      <= '0;
            r_zero     <= (data_in == '0);
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= StScan;
          end
        end
        StScan: begin
          r_work <= w_stage_word;
          r_amt  <= r_amt | w_amt_set;
          r_k    <= r_k + SEL_W'(1);
          if (r_k == K_LAST) begin
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_state     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign data_out  = r_work;
  assign shift_amt = r_amt;
  assign zero      = r_zero;

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed and random checks of shift_normalizer; a left and a right instance share stimulus.
module tb_shift_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] data_in;
  logic        out_ready;

  logic        in_ready_l, out_valid_l, zero_l;
  logic [15:0] data_out_l;
  logic [3:0]  shift_amt_l;
  logic        in_ready_r, out_valid_r, zero_r;
  logic [15:0] data_out_r;
  logic [3:0]  shift_amt_r;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  shift_normalizer #(.DATA_SIZE(16), .DIRECTION(1'b1)) u_dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l), .data_in(data_in),
    .out_valid(out_valid_l), .out_ready(out_ready), .data_out(data_out_l),
    .shift_amt(shift_amt_l), .zero(zero_l)
  );

  shift_normalizer #(.DATA_SIZE(16), .DIRECTION(1'b0)) u_dut_r (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r), .data_in(data_in),
    .out_valid(out_valid_r), .out_ready(out_ready), .data_out(data_out_r),
    .shift_amt(shift_amt_r), .zero(zero_r)
  );

  function automatic int ref_clz(input logic [15:0] w);
    int n = 0;
    for (int i = 15; i >= 0; i--) begin
      if (w[i]) break;
      n++;
    end
    return (n == 16) ? 15 : n;
  endfunction

  function automatic int ref_ctz(input logic [15:0] w);
    int n = 0;
    for (int i = 0; i < 16; i++) begin
      if (w[i]) break;
      n++;
    end
    return (n == 16) ? 15 : n;
  endfunction

  // Presents a word once in_ready is seen, then counts edges until out_valid (bounded).
  task automatic feed(input logic [15:0] word, output int lat);
    int guard = 0;
    while (!in_ready_l && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b1;
    data_in  = word;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid_l && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; data_in = 16'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_chk++;
    if (in_ready_l !== 1'b1 || out_valid_l !== 1'b0 || in_ready_r !== 1'b1 || out_valid_r !== 1'b0) begin
      n_err++;
      $display("FAIL reset_handshake: in_ready=%b/%b out_valid=%b/%b, required 1/1 0/0",
               in_ready_l, in_ready_r, out_valid_l, out_valid_r);
    end
    n_chk++;
    if (data_out_l !== 16'h0 || shift_amt_l !== 4'h0 || zero_l !== 1'b0 ||
        data_out_r !== 16'h0 || shift_amt_r !== 4'h0 || zero_r !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: L %h/%0d/%b R %h/%0d/%b, required all zero",
               data_out_l, shift_amt_l, zero_l, data_out_r, shift_amt_r, zero_r);
    end
  endtask

  task automatic test_lzc_basic();
    int lat;
    feed(16'h1901, lat);
    n_chk++;
    if (lat !== 4) begin
      n_err++;
      $display("FAIL latency_1901: got %0d cycles, required 4", lat);
    end
    n_chk++;
    if (data_out_l !== 16'hC808 || shift_amt_l !== 4'd3 || zero_l !== 1'b0) begin
      n_err++;
      $display("FAIL lzc_1901: got %h amt=%0d zero=%b, required c808 amt=3 zero=0",
               data_out_l, shift_amt_l, zero_l);
    end
    n_chk++;
    if (data_out_r !== 16'h1901 || shift_amt_r !== 4'd0) begin
      n_err++;
      $display("FAIL tzc_1901: got %h amt=%0d, required 1901 amt=0", data_out_r, shift_amt_r);
    end
    release_out();
  endtask

  task automatic test_lzc_edges();
    int lat;
    feed(16'h978B, lat);
    n_chk++;
    if (data_out_l !== 16'h978B || shift_amt_l !== 4'd0) begin
      n_err++;
      $display("FAIL lzc_msb_set: got %h amt=%0d, required 978b amt=0", data_out_l, shift_amt_l);
    end
    release_out();
    feed(16'h0001, lat);
    n_chk++;
    if (data_out_l !== 16'h8000 || shift_amt_l !== 4'd15 || zero_l !== 1'b0) begin
      n_err++;
      $display("FAIL lzc_0001: got %h amt=%0d zero=%b, required 8000 amt=15 zero=0",
               data_out_l, shift_amt_l, zero_l);
    end
    n_chk++;
    if (data_out_r !== 16'h0001 || shift_amt_r !== 4'd0) begin
      n_err++;
      $display("FAIL tzc_lsb_set: got %h amt=%0d, required 0001 amt=0", data_out_r, shift_amt_r);
    end
    release_out();
  endtask

  task automatic test_zero();
    int lat;
    feed(16'h0000, lat);
    n_chk++;
    if (data_out_l !== 16'h0000 || shift_amt_l !== 4'd15 || zero_l !== 1'b1) begin
      n_err++;
      $display("FAIL zero_left: got %h amt=%0d zero=%b, required 0000 amt=15 zero=1",
               data_out_l, shift_amt_l, zero_l);
    end
    n_chk++;
    if (data_out_r !== 16'h0000 || shift_amt_r !== 4'd15 || zero_r !== 1'b1) begin
      n_err++;
      $display("FAIL zero_right: got %h amt=%0d zero=%b, required 0000 amt=15 zero=1",
               data_out_r, shift_amt_r, zero_r);
    end
    release_out();
  endtask

  task automatic test_tzc();
    int lat;
    feed(16'h1188, lat);
    n_chk++;
    if (data_out_r !== 16'h0231 || shift_amt_r !== 4'd3 || zero_r !== 1'b0) begin
      n_err++;
      $display("FAIL tzc_1188: got %h amt=%0d zero=%b, required 0231 amt=3 zero=0",
               data_out_r, shift_amt_r, zero_r);
    end
    release_out();
    feed(16'h8000, lat);
    n_chk++;
    if (data_out_r !== 16'h0001 || shift_amt_r !== 4'd15) begin
      n_err++;
      $display("FAIL tzc_8000: got %h amt=%0d, required 0001 amt=15", data_out_r, shift_amt_r);
    end
    n_chk++;
    if (data_out_l !== 16'h8000 || shift_amt_l !== 4'd0) begin
      n_err++;
      $display("FAIL lzc_8000: got %h amt=%0d, required 8000 amt=0", data_out_l, shift_amt_l);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    int lat;
    feed(16'h2A00, lat);
    for (int c = 0; c < 5; c++) begin
      in_valid = (c == 1);
      data_in  = 16'h00F0;
      @(posedge clk); #1;
      n_chk++;
      if (out_valid_l !== 1'b1 || in_ready_l !== 1'b0 || data_out_l !== 16'hA800 ||
          shift_amt_l !== 4'd2 || zero_l !== 1'b0) begin
        n_err++;
        $display("FAIL hold_cycle%0d: valid=%b ready=%b out=%h amt=%0d, required 1 0 a800 2",
                 c, out_valid_l, in_ready_l, data_out_l, shift_amt_l);
      end
    end
    in_valid = 1'b0;
    release_out();
    n_chk++;
    if (out_valid_l !== 1'b0 || in_ready_l !== 1'b1) begin
      n_err++;
      $display("FAIL hold_release: valid=%b ready=%b, required 0 1", out_valid_l, in_ready_l);
    end
    repeat (8) @(posedge clk);
    #1;
    n_chk++;
    if (out_valid_l !== 1'b0 || in_ready_l !== 1'b1 || out_valid_r !== 1'b0) begin
      n_err++;
      $display("FAIL dropped_word: valid=%b/%b ready=%b, required 0/0 1",
               out_valid_l, out_valid_r, in_ready_l);
    end
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    in_valid = 1'b1;
    data_in  = 16'h00F3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_chk++;
    if (in_ready_l !== 1'b1 || out_valid_l !== 1'b0 || data_out_l !== 16'h0 ||
        shift_amt_l !== 4'h0 || zero_l !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_scan: ready=%b valid=%b out=%h amt=%0d zero=%b, required 1 0 0 0 0",
               in_ready_l, out_valid_l, data_out_l, shift_amt_l, zero_l);
    end
    feed(16'h0100, lat);
    n_chk++;
    if (data_out_l !== 16'h8000 || shift_amt_l !== 4'd7) begin
      n_err++;
      $display("FAIL after_reset_0100: got %h amt=%0d, required 8000 amt=7",
               data_out_l, shift_amt_l);
    end
    n_chk++;
    if (data_out_r !== 16'h0001 || shift_amt_r !== 4'd8) begin
      n_err++;
      $display("FAIL after_reset_0100_r: got %h amt=%0d, required 0001 amt=8",
               data_out_r, shift_amt_r);
    end
    release_out();
  endtask

  // With both handshakes held high a new word is taken every SEL_W+2 = 6 cycles.
  task automatic test_back_to_back();
    int accepts = 0;
    int results = 0;
    in_valid  = 1'b1;
    data_in   = 16'h0F00;
    out_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      if (in_ready_l) accepts++;
      @(posedge clk); #1;
      if (out_valid_l) begin
        results++;
        n_chk++;
        if (data_out_l !== 16'hF000 || shift_amt_l !== 4'd4 ||
            data_out_r !== 16'h000F || shift_amt_r !== 4'd8) begin
          n_err++;
          $display("FAIL b2b_result: L %h/%0d R %h/%0d, required f000/4 000f/8",
                   data_out_l, shift_amt_l, data_out_r, shift_amt_r);
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_chk++;
    if (accepts !== 3 || results !== 3) begin
      n_err++;
      $display("FAIL b2b_throughput: accepts=%0d results=%0d, required 3 3", accepts, results);
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [15:0] w, exp_l, exp_r;
    int lat, cl, ct;
    for (int n = 0; n < 1000; n++) begin
      w = 16'($urandom);
      if (n % 3 == 0) w = w >> $urandom_range(0, 15);
      else if (n % 3 == 1) w = w << $urandom_range(0, 15);
      cl    = ref_clz(w);
      ct    = ref_ctz(w);
      exp_l = w << cl;
      exp_r = w >> ct;
      feed(w, lat);
      n_chk++;
      if (lat !== 4 || data_out_l !== exp_l || shift_amt_l !== 4'(cl) || zero_l !== (w == 16'h0)) begin
        n_err++;
        $display("FAIL rand_left w=%h: lat=%0d out=%h amt=%0d zero=%b, required 4 %h %0d %b",
                 w, lat, data_out_l, shift_amt_l, zero_l, exp_l, cl, (w == 16'h0));
      end
      n_chk++;
      if (data_out_r !== exp_r || shift_amt_r !== 4'(ct) || zero_r !== (w == 16'h0)) begin
        n_err++;
        $display("FAIL rand_right w=%h: out=%h amt=%0d zero=%b, required %h %0d %b",
                 w, data_out_r, shift_amt_r, zero_r, exp_r, ct, (w == 16'h0));
      end
      if (w != 16'h0) begin
        n_chk++;
        if (data_out_l[15] !== 1'b1 || data_out_r[0] !== 1'b1) begin
          n_err++;
          $display("FAIL rand_norm w=%h: msb=%b lsb=%b, required 1 1",
                   w, data_out_l[15], data_out_r[0]);
        end
      end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_lzc_basic();
    test_lzc_edges();
    test_zero();
    test_tzc();
    test_backpressure();
    test_reset_mid_scan();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
